// File: rtl/chan_mux_if.sv
// Bundles the channel-side data/valid/ack and the downstream output handshake of chan_mux.
// No storage of its own; latency is that of the module attached to it.
// Backpressure is carried by RDY from the consumer back to the mux.
interface chan_mux_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SW    = $clog2(NCH)
);
    logic [NCH*WIDTH-1:0] D;
    logic [NCH-1:0]       V;
    logic [NCH-1:0]       ACK;
    logic                 MODE;
    logic [SW-1:0]        S;
    logic [WIDTH-1:0]     Y;
    logic                 YV;
    logic [SW-1:0]        YCH;
    logic                 RDY;

    // Producer/consumer side: drives channels and select, sees the registered output.
    modport master (
        output D, V, MODE, S, RDY,
        input  ACK, Y, YV, YCH
    );

    // Mux side.
    modport slave (
        input  D, V, MODE, S, RDY,
        output ACK, Y, YV, YCH
    );
endinterface

// File: rtl/chan_mux.sv
// Selects one of NCH channels (fixed by S or round-robin) into a single registered output word.
// Latency: one cycle from ACK[c] to Y/YV/YCH showing channel c.
// Backpressure: while YV && !RDY the output holds, no channel is acked and the RR pointer freezes.
module chan_mux #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SW    = $clog2(NCH)
) (
    input  logic         clk,
    input  logic         rst,
    chan_mux_if.slave    bus
);
    localparam int NP = 1 << SW;

    logic [WIDTH-1:0] y_q;
    logic             yv_q;
    logic [SW-1:0]    ych_q;
    logic [SW-1:0]    p_q;

    logic             ld;
    logic [NP-1:0]    v_pad;
    logic             fix_ok;
    logic             rr_found;
    logic [SW-1:0]    rr_win;
    logic             take;
    logic [SW-1:0]    win;
    logic [SW-1:0]    p_next;
    logic [NCH-1:0]   ack;

    // Output slot is free when empty or being drained this cycle.
    assign ld = !yv_q || bus.RDY;

    // Fixed-select qualification; pad V so any S value indexes safely.
    always_comb begin
        v_pad          = '0;
        v_pad[NCH-1:0] = bus.V;
        fix_ok         = (int'(bus.S) < NCH) && v_pad[bus.S];
    end

    // Round-robin search: first valid channel starting at the pointer, wrapping.
    always_comb begin
        int idx;
        idx      = 0;
        rr_found = 1'b0;
        rr_win   = '0;
        for (int i = 0; i < NCH; i++) begin
            idx = (int'(p_q) + i) % NCH;
            if (!rr_found && bus.V[idx]) begin
                rr_found = 1'b1;
                rr_win   = SW'(idx);
            end
        end
    end

    // Pick the winning channel for this cycle and form the one-hot ack.
    always_comb begin
        take = 1'b0;
        win  = bus.S;
        if (bus.MODE) begin
            take = ld && rr_found;
            win  = rr_win;
        end else begin
            take = ld && fix_ok;
            win  = bus.S;
        end
        ack = '0;
        if (take && !rst) begin
            ack = NCH'(1) << win;
        end
        p_next = (int'(win) == NCH - 1) ? '0 : SW'(win + 1'b1);
    end

    assign bus.ACK = ack;
    assign bus.Y   = y_q;
    assign bus.YV  = yv_q;
    assign bus.YCH = ych_q;

    // Output register and RR pointer; reset drops any held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q   <= '0;
            yv_q  <= 1'b0;
            ych_q <= '0;
            p_q   <= '0;
        end else if (ld) begin
            if (take) begin
                y_q   <= bus.D[int'(win)*WIDTH +: WIDTH];
                yv_q  <= 1'b1;
                ych_q <= win;
                if (bus.MODE) begin
                    p_q <= p_next;
                end
            end else begin
                yv_q <= 1'b0;
            end
        end
    end
endmodule

// File: doc/chan_mux.md
CHAN_MUX -- requirements
Module: chan_mux

Interface
- REQ-001: Parameter WIDTH, default 8, data width per channel.
- REQ-002: Parameter NCH, default 4, channel count (2..16).
- REQ-003: Parameter SW, default $clog2(NCH), select/index width.
- REQ-004: Port clk, input, 1, sole clock, rising edge.
- REQ-005: Port rst, input, 1. Reset is synchronous and active-high.
- REQ-006: Port D, input, NCH*WIDTH, channel data; channel c at D[c*WIDTH +: WIDTH].
- REQ-007: Port V, input, NCH, per-channel valid.
- REQ-008: Port ACK, output, NCH, one-hot; channel c consumed this cycle.
- REQ-009: Port MODE, input, 1; 0 = fixed select by S, 1 = round-robin.
- REQ-010: Port S, input, SW, fixed-mode channel select.
- REQ-011: Port Y, output, WIDTH, registered selected data.
- REQ-012: Port YV, output, 1, Y valid.
- REQ-013: Port YCH, output, SW, source channel index of Y.
- REQ-014: Port RDY, input, 1, downstream accepts Y when YV&&RDY.

Function
- REQ-015: Output slot free (load enable LD) when !YV || RDY; all state updates on rising clk only.
- REQ-016: Stall: YV=1 && RDY=0 -> Y, YV, YCH, rotate pointer P unchanged; ACK=0.
- REQ-017: Fixed mode, LD, S<NCH, V[S]=1 -> next Y=D[S], YV=1, YCH=S; ACK[S]=1 this cycle.
- REQ-018: Fixed mode, LD, V[S]=0 or S>=NCH -> next YV=0, Y/YCH hold; ACK=0.
- REQ-019: RR mode: internal pointer P (SW bits, range 0..NCH-1); winner c = first channel with V[c]=1 scanning P, P+1, ... wrapping modulo NCH.
- REQ-020: RR mode, LD, winner c exists -> next Y=D[c], YV=1, YCH=c, P=(c+1) mod NCH; ACK[c]=1 this cycle.
- REQ-021: RR mode, LD, V=0 -> next YV=0, P unchanged; ACK=0.
- REQ-022: ACK combinational from current V, S, MODE, P, YV, RDY; at most one bit high.
- REQ-023: Wrap: winner NCH-1 -> P=0.
- REQ-024: Simultaneous RDY=1 with new valid channel: old word retired and new word loaded same edge (full throughput, one word/cycle).
- REQ-025: MODE/S changes take effect on next LD; P retained across mode changes, not updated in fixed mode.
- REQ-026: Latency: one cycle from ACK[c] to Y/YV reflecting channel c.

Reset
- REQ-027: rst=1 at edge -> Y=0, YV=0, YCH=0, P=0; overrides all other inputs.
- REQ-028: ACK=0 whenever rst=1.
- REQ-029: Reset mid-stall drops held word; no ACK in first cycle after reset unless LD conditions met.

Verification (NCH=4, WIDTH=8)
- REQ-030: rst 1 cycle -> Y=0x00, YV=0, YCH=0, ACK=0000.
- REQ-031: MODE=0, S=2, V=0100, D[2]=0xA5, RDY=1 -> ACK=0100, next cycle Y=0xA5, YV=1, YCH=2; then V=0000 -> YV=0.
- REQ-032: MODE=1, V=1111 held, RDY=1, D[c]=0x10+c -> YCH sequence 0,1,2,3,0; Y 0x10,0x11,0x12,0x13,0x10; one ACK bit per cycle.
- REQ-033: MODE=1, Y holding ch1, RDY=0 for 3 cycles with V=1111 -> Y/YCH stable, ACK=0000; RDY=1 -> next YCH=2.
- REQ-034: MODE=1, P=3, V=0010 -> YCH=1, P becomes 2; V=1001 next -> YCH=3, P wraps to 0.
- REQ-035: rst asserted during stall (YV=1, RDY=0) -> next cycle YV=0, Y=0x00, P=0; subsequent RR grant starts at ch0.
